// File: rtl/l2_slave_rr_arbiter.sv
// Per-bank L2 slave arbiter: round-robin selection among master decoders,
// stall-safe locking of the selected master, and 1-cycle response tracking.
module l2_slave_rr_arbiter #(
  parameter int unsigned N_MASTER   = 4,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_MASTER-1:0]                   data_req_i,
  input  logic [N_MASTER*ADDR_WIDTH-1:0]        data_add_i,
  input  logic [N_MASTER-1:0]                   data_wen_i,
  input  logic [N_MASTER*DATA_WIDTH-1:0]        data_wdata_i,
  input  logic [N_MASTER*(DATA_WIDTH/8)-1:0]    data_be_i,
  input  logic [N_MASTER*ID_WIDTH-1:0]          data_ID_i,
  output logic [N_MASTER-1:0]                   data_gnt_o,
  output logic                                  data_req_o,
  output logic [ADDR_WIDTH-1:0]                 data_add_o,
  output logic                                  data_wen_o,
  output logic [DATA_WIDTH-1:0]                 data_wdata_o,
  output logic [DATA_WIDTH/8-1:0]               data_be_o,
  output logic [ID_WIDTH-1:0]                   data_ID_o,
  input  logic                                  data_gnt_i,
  output logic [N_MASTER-1:0]                   data_r_valid_o,
  output logic [ID_WIDTH-1:0]                   data_r_ID_o
);

  localparam int unsigned MIDX_W   = $clog2(N_MASTER);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [MIDX_W-1:0]   lock_idx_q, lock_idx_d;
  logic [MIDX_W-1:0]   prio_ptr_q;
  logic [MIDX_W-1:0]   rr_idx, winner, sel_idx;
  logic                rr_found;
  int unsigned         cand;
  logic                req_any, handshake;

  logic                resp_valid_q;
  logic [MIDX_W-1:0]   resp_idx_q;
  logic [ID_WIDTH-1:0] resp_id_q;

  logic [ADDR_WIDTH-1:0] add_arr   [N_MASTER];
  logic [DATA_WIDTH-1:0] wdata_arr [N_MASTER];
  logic [BE_WIDTH-1:0]   be_arr    [N_MASTER];
  logic [ID_WIDTH-1:0]   id_arr    [N_MASTER];

  // Unpack the per-master payload buses into indexable arrays
  for (genvar g = 0; g < N_MASTER; g++) begin : g_unpack
    assign add_arr[g]   = data_add_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = data_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign be_arr[g]    = data_be_i[g*BE_WIDTH +: BE_WIDTH];
    assign id_arr[g]    = data_ID_i[g*ID_WIDTH +: ID_WIDTH];
  end

  // First requester at or after the priority pointer, wrapping modulo N_MASTER
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    cand     = 0;
    for (int unsigned k = 0; k < N_MASTER; k++) begin
      cand = 32'(prio_ptr_q) + k;
      if (cand >= N_MASTER) cand = cand - N_MASTER;
      if (!rr_found && data_req_i[MIDX_W'(cand)]) begin
        rr_idx   = MIDX_W'(cand);
        rr_found = 1'b1;
      end
    end
  end

  assign winner    = (state_q == LOCKED) ? lock_idx_q : rr_idx;
  assign req_any   = |data_req_i;
  assign handshake = req_any & data_gnt_i;
  assign sel_idx   = req_any ? winner : '0;

  assign data_req_o   = req_any;
  assign data_add_o   = add_arr[sel_idx];
  assign data_wen_o   = data_wen_i[sel_idx];
  assign data_wdata_o = wdata_arr[sel_idx];
  assign data_be_o    = be_arr[sel_idx];
  assign data_ID_o    = id_arr[sel_idx];
  assign data_gnt_o   = handshake ? (N_MASTER'(1'b1) << winner) : '0;

  // Hold the winner across SRAM stalls so a pending request is never pre-empted
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      FREE: begin
        if (req_any && !data_gnt_i) begin
          state_d    = LOCKED;
          lock_idx_d = winner;
        end
      end
      LOCKED: begin
        if (handshake) state_d = FREE;
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FREE;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_ptr_q <= '0;
    end else if (handshake) begin
      prio_ptr_q <= (winner == MIDX_W'(N_MASTER - 1)) ? '0 : winner + 1'b1;
    end
  end

  // SRAM read latency is one cycle: echo the served master and its ID
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
      resp_id_q    <= '0;
    end else begin
      resp_valid_q <= handshake;
      resp_idx_q   <= winner;
      resp_id_q    <= data_ID_o;
    end
  end

  assign data_r_valid_o = resp_valid_q ? (N_MASTER'(1'b1) << resp_idx_q) : '0;
  assign data_r_ID_o    = resp_id_q;

  a_lock_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == LOCKED) |-> data_req_i[lock_idx_q]);

endmodule

// File: tb/tb_l2_slave_rr_arbiter.sv
// Directed bench for l2_slave_rr_arbiter: a 4-master and a 3-master instance.
module tb_l2_slave_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-master instance
  logic [3:0]   req4, wen4, gnt4, rv4;
  logic [47:0]  add4;
  logic [127:0] wdata4;
  logic [15:0]  be4, id4;
  logic         gnt_i4, req_o4, wen_o4;
  logic [11:0]  add_o4;
  logic [31:0]  wdata_o4;
  logic [3:0]   be_o4, id_o4, r_id4;

  // 3-master instance
  logic [2:0]   req3, wen3, gnt3, rv3;
  logic [35:0]  add3;
  logic [95:0]  wdata3;
  logic [11:0]  be3, id3;
  logic         gnt_i3, req_o3, wen_o3;
  logic [11:0]  add_o3;
  logic [31:0]  wdata_o3;
  logic [3:0]   be_o3, id_o3, r_id3;

  int n_cmp = 0;
  int n_err = 0;

  l2_slave_rr_arbiter #(.N_MASTER(4)) dut4 (
    .clk(clk), .rst(rst),
    .data_req_i(req4), .data_add_i(add4), .data_wen_i(wen4),
    .data_wdata_i(wdata4), .data_be_i(be4), .data_ID_i(id4),
    .data_gnt_o(gnt4), .data_req_o(req_o4), .data_add_o(add_o4),
    .data_wen_o(wen_o4), .data_wdata_o(wdata_o4), .data_be_o(be_o4),
    .data_ID_o(id_o4), .data_gnt_i(gnt_i4),
    .data_r_valid_o(rv4), .data_r_ID_o(r_id4)
  );

  l2_slave_rr_arbiter #(.N_MASTER(3)) dut3 (
    .clk(clk), .rst(rst),
    .data_req_i(req3), .data_add_i(add3), .data_wen_i(wen3),
    .data_wdata_i(wdata3), .data_be_i(be3), .data_ID_i(id3),
    .data_gnt_o(gnt3), .data_req_o(req_o3), .data_add_o(add_o3),
    .data_wen_o(wen_o3), .data_wdata_o(wdata_o3), .data_be_o(be_o3),
    .data_ID_o(id_o3), .data_gnt_i(gnt_i3),
    .data_r_valid_o(rv3), .data_r_ID_o(r_id3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (req_o4 !== 1'b0) begin n_err++; $display("FAIL reset_req_o c%0d: got %b want 0", c, req_o4); end
      n_cmp++; if (gnt4 !== 4'b0000) begin n_err++; $display("FAIL reset_gnt c%0d: got %b want 0000", c, gnt4); end
      n_cmp++; if (rv4 !== 4'b0000) begin n_err++; $display("FAIL reset_rvalid c%0d: got %b want 0000", c, rv4); end
      n_cmp++; if (r_id4 !== 4'h0) begin n_err++; $display("FAIL reset_rid c%0d: got %h want 0", c, r_id4); end
      n_cmp++; if (rv3 !== 3'b000) begin n_err++; $display("FAIL reset_rvalid3 c%0d: got %b want 000", c, rv3); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g, exp_rv, exp_id, exp_rid;
    req4 = 4'hF; gnt_i4 = 1'b1; id4 = 16'hDCBA;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_g  = 4'b0001 << (c % 4);
      exp_id = 4'hA + 4'(c % 4);
      n_cmp++; if (gnt4 !== exp_g) begin n_err++; $display("FAIL rr_gnt c%0d: got %b want %b", c, gnt4, exp_g); end
      n_cmp++; if (id_o4 !== exp_id) begin n_err++; $display("FAIL rr_id c%0d: got %h want %h", c, id_o4, exp_id); end
      exp_rv  = (c == 0) ? 4'b0000 : 4'b0001 << ((c - 1) % 4);
      exp_rid = (c == 0) ? 4'h0 : 4'hA + 4'((c - 1) % 4);
      n_cmp++; if (rv4 !== exp_rv) begin n_err++; $display("FAIL rr_rvalid c%0d: got %b want %b", c, rv4, exp_rv); end
      n_cmp++; if (r_id4 !== exp_rid) begin n_err++; $display("FAIL rr_rid c%0d: got %h want %h", c, r_id4, exp_rid); end
      tick();
    end
    req4 = 4'h0;
    @(negedge clk);
    n_cmp++; if (rv4 !== 4'b1000) begin n_err++; $display("FAIL rr_last_rvalid: got %b want 1000", rv4); end
    n_cmp++; if (r_id4 !== 4'hD) begin n_err++; $display("FAIL rr_last_rid: got %h want d", r_id4); end
    tick();
  endtask

  task automatic test_single_rw();
    add4 = '0; add4[35:24] = 12'h3A0;
    id4 = 16'h9500;
    wen4 = 4'b0111; wdata4 = '0; wdata4[127:96] = 32'hDEADBEEF;
    be4 = '0; be4[15:12] = 4'b0110;
    gnt_i4 = 1'b1;
    req4 = 4'b1000;
    @(negedge clk);
    n_cmp++; if (gnt4 !== 4'b1000) begin n_err++; $display("FAIL wr_gnt: got %b want 1000", gnt4); end
    n_cmp++; if (wen_o4 !== 1'b0) begin n_err++; $display("FAIL wr_wen: got %b want 0", wen_o4); end
    n_cmp++; if (wdata_o4 !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_wdata: got %h want deadbeef", wdata_o4); end
    n_cmp++; if (be_o4 !== 4'b0110) begin n_err++; $display("FAIL wr_be: got %b want 0110", be_o4); end
    n_cmp++; if (id_o4 !== 4'h9) begin n_err++; $display("FAIL wr_id: got %h want 9", id_o4); end
    tick();
    req4 = 4'b0100;
    @(negedge clk);
    n_cmp++; if (gnt4 !== 4'b0100) begin n_err++; $display("FAIL rd_gnt: got %b want 0100", gnt4); end
    n_cmp++; if (add_o4 !== 12'h3A0) begin n_err++; $display("FAIL rd_add: got %h want 3a0", add_o4); end
    n_cmp++; if (wen_o4 !== 1'b1) begin n_err++; $display("FAIL rd_wen: got %b want 1", wen_o4); end
    n_cmp++; if (id_o4 !== 4'h5) begin n_err++; $display("FAIL rd_id: got %h want 5", id_o4); end
    n_cmp++; if (rv4 !== 4'b1000) begin n_err++; $display("FAIL wr_rvalid: got %b want 1000", rv4); end
    n_cmp++; if (r_id4 !== 4'h9) begin n_err++; $display("FAIL wr_rid: got %h want 9", r_id4); end
    tick();
    req4 = 4'b0000;
    @(negedge clk);
    n_cmp++; if (rv4 !== 4'b0100) begin n_err++; $display("FAIL rd_rvalid: got %b want 0100", rv4); end
    n_cmp++; if (r_id4 !== 4'h5) begin n_err++; $display("FAIL rd_rid: got %h want 5", r_id4); end
    tick();
    wen4 = 4'hF;
  endtask

  // Pointer sits at 3 here, so an unlocked arbiter would switch to master 3
  task automatic test_stall_lock();
    add4 = {12'h3C3, 12'h3A0, 12'h1B1, 12'h0A0};
    id4  = 16'h9521;
    gnt_i4 = 1'b0;
    req4 = 4'b0011;
    @(negedge clk);
    n_cmp++; if (gnt4 !== 4'b0000) begin n_err++; $display("FAIL stall_gnt c0: got %b want 0000", gnt4); end
    n_cmp++; if (req_o4 !== 1'b1) begin n_err++; $display("FAIL stall_req_o: got %b want 1", req_o4); end
    n_cmp++; if (add_o4 !== 12'h0A0) begin n_err++; $display("FAIL stall_add c0: got %h want 0a0", add_o4); end
    n_cmp++; if (rv4 !== 4'b0000) begin n_err++; $display("FAIL stall_rvalid: got %b want 0000", rv4); end
    tick();
    req4 = 4'b1011;
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (gnt4 !== 4'b0000) begin n_err++; $display("FAIL stall_gnt c%0d: got %b want 0000", c, gnt4); end
      n_cmp++; if (add_o4 !== 12'h0A0) begin n_err++; $display("FAIL stall_add c%0d: got %h want 0a0", c, add_o4); end
      tick();
    end
    gnt_i4 = 1'b1;
    @(negedge clk);
    n_cmp++; if (gnt4 !== 4'b0001) begin n_err++; $display("FAIL stall_release_gnt: got %b want 0001", gnt4); end
    tick();
    req4 = 4'b1010;
    @(negedge clk);
    n_cmp++; if (gnt4 !== 4'b0010) begin n_err++; $display("FAIL stall_next_gnt: got %b want 0010", gnt4); end
    n_cmp++; if (rv4 !== 4'b0001) begin n_err++; $display("FAIL stall_rvalid0: got %b want 0001", rv4); end
    n_cmp++; if (r_id4 !== 4'h1) begin n_err++; $display("FAIL stall_rid0: got %h want 1", r_id4); end
    tick();
    req4 = 4'b1000;
    @(negedge clk);
    n_cmp++; if (gnt4 !== 4'b1000) begin n_err++; $display("FAIL stall_m3_gnt: got %b want 1000", gnt4); end
    n_cmp++; if (rv4 !== 4'b0010) begin n_err++; $display("FAIL stall_rvalid1: got %b want 0010", rv4); end
    tick();
    req4 = 4'b0000;
    @(negedge clk);
    n_cmp++; if (rv4 !== 4'b1000) begin n_err++; $display("FAIL stall_rvalid3: got %b want 1000", rv4); end
    n_cmp++; if (r_id4 !== 4'h9) begin n_err++; $display("FAIL stall_rid3: got %h want 9", r_id4); end
    tick();
  endtask

  // Reset while locked on master 1 with pointer at 2; a grant in the reset cycle must not echo
  task automatic test_reset_mid();
    gnt_i4 = 1'b1;
    req4 = 4'b0010;
    @(negedge clk);
    n_cmp++; if (gnt4 !== 4'b0010) begin n_err++; $display("FAIL rmid_pre_gnt: got %b want 0010", gnt4); end
    tick();
    gnt_i4 = 1'b0;
    @(negedge clk);
    n_cmp++; if (gnt4 !== 4'b0000) begin n_err++; $display("FAIL rmid_stall_gnt: got %b want 0000", gnt4); end
    tick();
    rst = 1'b1; gnt_i4 = 1'b1;
    tick();
    rst = 1'b0;
    req4 = 4'b0111;
    @(negedge clk);
    n_cmp++; if (rv4 !== 4'b0000) begin n_err++; $display("FAIL rmid_rvalid: got %b want 0000", rv4); end
    n_cmp++; if (r_id4 !== 4'h0) begin n_err++; $display("FAIL rmid_rid: got %h want 0", r_id4); end
    n_cmp++; if (gnt4 !== 4'b0001) begin n_err++; $display("FAIL rmid_ptr_gnt: got %b want 0001", gnt4); end
    tick();
    req4 = 4'b0110;
    @(negedge clk);
    n_cmp++; if (gnt4 !== 4'b0010) begin n_err++; $display("FAIL rmid_m1_gnt: got %b want 0010", gnt4); end
    n_cmp++; if (rv4 !== 4'b0001) begin n_err++; $display("FAIL rmid_m0_rvalid: got %b want 0001", rv4); end
    tick();
    req4 = 4'b0100;
    @(negedge clk);
    n_cmp++; if (gnt4 !== 4'b0100) begin n_err++; $display("FAIL rmid_m2_gnt: got %b want 0100", gnt4); end
    n_cmp++; if (rv4 !== 4'b0010) begin n_err++; $display("FAIL rmid_m1_rvalid: got %b want 0010", rv4); end
    tick();
    req4 = 4'b0000;
    tick();
  endtask

  // Three masters: pointer 2 must wrap explicitly to 0
  task automatic test_wrap3();
    add3 = {12'h222, 12'h111, 12'h000};
    id3  = 12'h765;
    gnt_i3 = 1'b1;
    req3 = 3'b010;
    @(negedge clk);
    n_cmp++; if (gnt3 !== 3'b010) begin n_err++; $display("FAIL wrap_m1_gnt: got %b want 010", gnt3); end
    tick();
    req3 = 3'b101;
    @(negedge clk);
    n_cmp++; if (gnt3 !== 3'b100) begin n_err++; $display("FAIL wrap_m2_gnt: got %b want 100", gnt3); end
    n_cmp++; if (add_o3 !== 12'h222) begin n_err++; $display("FAIL wrap_m2_add: got %h want 222", add_o3); end
    n_cmp++; if (rv3 !== 3'b010) begin n_err++; $display("FAIL wrap_m1_rvalid: got %b want 010", rv3); end
    tick();
    @(negedge clk);
    n_cmp++; if (gnt3 !== 3'b001) begin n_err++; $display("FAIL wrap_m0_gnt: got %b want 001", gnt3); end
    n_cmp++; if (rv3 !== 3'b100) begin n_err++; $display("FAIL wrap_m2_rvalid: got %b want 100", rv3); end
    n_cmp++; if (r_id3 !== 4'h7) begin n_err++; $display("FAIL wrap_m2_rid: got %h want 7", r_id3); end
    tick();
    req3 = 3'b100;
    @(negedge clk);
    n_cmp++; if (gnt3 !== 3'b100) begin n_err++; $display("FAIL wrap_m2_again_gnt: got %b want 100", gnt3); end
    n_cmp++; if (rv3 !== 3'b001) begin n_err++; $display("FAIL wrap_m0_rvalid: got %b want 001", rv3); end
    tick();
    req3 = 3'b000;
    @(negedge clk);
    n_cmp++; if (rv3 !== 3'b100) begin n_err++; $display("FAIL wrap_last_rvalid: got %b want 100", rv3); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req4 = '0; add4 = '0; wen4 = 4'hF; wdata4 = '0; be4 = '0; id4 = '0; gnt_i4 = 1'b0;
    req3 = '0; add3 = '0; wen3 = 3'h7; wdata3 = '0; be3 = '0; id3 = '0; gnt_i3 = 1'b0;
    test_reset();
    test_round_robin();
    test_single_rw();
    test_stall_lock();
    test_reset_mid();
    test_wrap3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/l2_slave_rr_arbiter.md
Name: l2_slave_rr_arbiter

Overview:
- Per-memory-cut arbitration stage of the L2 crossbar, sitting directly downstream of the per-master request address decoders.
- One instance per L2 bank. It collects the one-hot request lines that every master's decoder drives toward this bank, grants one master per cycle in round-robin order, and forwards that master's transaction to the SRAM cut.
- It also tracks the 1-cycle SRAM read latency and raises the response-valid line back to the master that was served.

Parameters:
- N_MASTER, 4, number of masters (decoder outputs) competing for this bank; must be ≥ 2.
- ADDR_WIDTH, 12, word address width into the SRAM cut.
- DATA_WIDTH, 32, data width; BE width is DATA_WIDTH/8.
- ID_WIDTH, 4, width of the master ID carried with each request.
- MIDX_W, $clog2(N_MASTER), master index width; derived, never overridden.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, reset; synchronous, active-high.
- data_req_i, input, N_MASTER, request bit from each master's decoder.
- data_add_i, input, N_MASTER*ADDR_WIDTH, per-master address, packed with master 0 in the LSBs.
- data_wen_i, input, N_MASTER, per-master write-enable, active-low (0 = write).
- data_wdata_i, input, N_MASTER*DATA_WIDTH, per-master write data.
- data_be_i, input, N_MASTER*DATA_WIDTH/8, per-master byte enables.
- data_ID_i, input, N_MASTER*ID_WIDTH, per-master ID.
- data_gnt_o, output, N_MASTER, grant to each master; at most one bit set.
- data_req_o, output, 1, request to the SRAM cut.
- data_add_o, output, ADDR_WIDTH, address of the selected master.
- data_wen_o, output, 1, write-enable of the selected master.
- data_wdata_o, output, DATA_WIDTH, write data of the selected master.
- data_be_o, output, DATA_WIDTH/8, byte enables of the selected master.
- data_ID_o, output, ID_WIDTH, ID of the selected master.
- data_gnt_i, input, 1, grant from the SRAM cut.
- data_r_valid_o, output, N_MASTER, one-hot response valid, asserted 1 cycle after the handshake.
- data_r_ID_o, output, ID_WIDTH, registered ID of the transaction being answered.

Behaviour:
- Reset state (rst=1 at a clock edge):
  - prio_ptr=0, lock=0, lock_idx=0, resp_valid register=0, resp ID register=0.
  - data_r_valid_o=0 and data_r_ID_o=0 from the first post-reset cycle.
  - data_req_o and data_gnt_o are combinational and are 0 whenever data_req_i=0.
- Winner selection (combinational):
  - If lock=1, winner=lock_idx.
  - Otherwise winner = first index i with data_req_i[i]=1, scanning prio_ptr, prio_ptr+1, ... modulo N_MASTER.
  - Modulo wrap is explicit, so non-power-of-2 N_MASTER is legal.
- Forwarding: data_req_o = OR of data_req_i. The data_add/wen/wdata/be/ID outputs mux the winner's slice; with no request, they mux slice 0.
- Grant: data_gnt_o[winner] = data_req_o & data_gnt_i; all other bits are 0.
- Handshake = data_req_o & data_gnt_i.
- State machine, two states:
  - FREE (lock=0): if data_req_o=1 and data_gnt_i=0, go to LOCKED with lock_idx=winner.
  - LOCKED (lock=1): the winner is held so that a master's stalled request is not pre-empted. On handshake, return to FREE.
- Pointer update: on every handshake, prio_ptr <= (winner==N_MASTER-1) ? 0 : winner+1. It is unchanged otherwise.
- Response tracking:
  - resp_valid <= handshake; resp_idx <= winner; resp_ID <= data_ID_o.
  - data_r_valid_o = resp_valid ? one-hot(resp_idx) : 0. data_r_ID_o = resp_ID.
  - Latency from handshake to r_valid is exactly 1 cycle. Reads and writes both produce r_valid.
- Back-to-back handshakes on consecutive cycles give consecutive r_valid pulses; there is no bubble.
- Masters keep data_req_i and payload stable until granted. A request that drops while LOCKED is a protocol violation; the lock is held regardless (checked by assertion).
- Simultaneous events:
  - A master granted this cycle may re-request the next cycle; it is lowest priority, after prio_ptr moves past it.
  - A handshake and a new request from another master in the same cycle are fine; the new request is arbitrated next cycle.
- rst asserted mid-transaction: lock, pointer and response register clear at that edge. No r_valid is emitted for a handshake that occurs in the reset cycle.

Test Plan:
- Reset, then data_req_i=4'b0000 for 3 cycles -> data_req_o=0, data_gnt_o=0, data_r_valid_o=0 every cycle.
- data_req_i=4'b1111 held, data_gnt_i=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3; data_r_valid_o one-hot repeats 0001,0010,0100,1000,... each lagging its grant by 1 cycle.
- Master 2 alone, read at data_add_i[2]=0x3A0, ID=0x5 -> data_add_o=0x3A0, data_gnt_o=0100; next cycle data_r_valid_o=0100, data_r_ID_o=0x5.
- data_req_i=0011, data_gnt_i=0 for 3 cycles, then 1 -> master 0 held selected throughout, despite master 1 requesting; data_gnt_o=0001 on the 4th cycle; master 1 granted on the 5th cycle.
- N_MASTER=3, masters 2 and 0 requesting with prio_ptr=2 -> master 2 granted; prio_ptr wraps to 0; master 0 granted next.
- rst=1 for one cycle while LOCKED with master 1 stalled -> lock=0, prio_ptr=0 after reset, data_r_valid_o=0; with master 1 still requesting, data_gnt_i=1 -> master 1 granted.
